noc_intr_rx: RTL

Receive-side endpoint for the off-chip interrupt packets produced by the chip's fake IOB. It consumes NoC flits over a val/rdy link and parses each header. Well-formed interrupt packets addressed to this tile are buffered and presented as decoded interrupt records on a val/rdy output; all other packets are drained and counted. It sits in a tile's or testbench's NoC input path, on the same 64-bit flit stream the IOB transmitter drives.

---
 rtl/noc_intr_rx_pkg.sv | 54 +++++
 rtl/noc_intr_rx_fifo.sv | 62 ++++++
 rtl/noc_intr_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/noc_intr_rx_pkg.sv
// Shared NoC header/payload field map and types for the interrupt receive endpoint.
package noc_intr_rx_pkg;

   // Link and coordinate widths
   localparam int NOC_DATA_WIDTH   = 64;
   localparam int NOC_X_WIDTH      = 8;
   localparam int NOC_Y_WIDTH      = 8;

   // Header flit field ranges
   localparam int MSG_DST_X_HI     = 49;
   localparam int MSG_DST_X_LO     = 42;
   localparam int MSG_DST_Y_HI     = 41;
   localparam int MSG_DST_Y_LO     = 34;
   localparam int MSG_LENGTH_HI    = 29;
   localparam int MSG_LENGTH_LO    = 22;
   localparam int MSG_TYPE_HI      = 21;
   localparam int MSG_TYPE_LO      = 14;
   localparam int MSG_LENGTH_WIDTH = 8;
   localparam int MSG_TYPE_WIDTH   = 8;

   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_INTERRUPT = 8'd32;

   // Interrupt payload field positions
   localparam int INTR_TILE_HI     = 49;
   localparam int INTR_TILE_LO     = 18;
   localparam int INTR_TYPE_HI     = 17;
   localparam int INTR_TYPE_LO     = 16;
   localparam int INTR_LOW_HI      = 8;
   localparam int INTR_LOW_LO      = 0;

   localparam int INTR_REC_WIDTH   = 43;

   typedef enum logic [1:0] {
      ST_HDR   = 2'd0,
      ST_CAPT  = 2'd1,
      ST_DRAIN = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [31:0] tile;
      logic [1:0]  itype;
      logic [8:0]  low;
   } intr_rec_t;

   // Extract the decoded interrupt record from a payload flit; bits [15:9] are not part of it.
   function automatic intr_rec_t decode_payload(input logic [NOC_DATA_WIDTH-1:0] p);
      intr_rec_t rec;
      rec.tile  = p[INTR_TILE_HI:INTR_TILE_LO];
      rec.itype = p[INTR_TYPE_HI:INTR_TYPE_LO];
      rec.low   = p[INTR_LOW_HI:INTR_LOW_LO];
      return rec;
   endfunction

endpackage

// File: rtl/noc_intr_rx_fifo.sv
// Synchronous FIFO holding decoded interrupt records; extra pointer bit separates full from empty.
module noc_intr_fifo
   import noc_intr_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      i_push,
   input  intr_rec_t i_data,
   input  logic      i_pop,
   output logic      o_full,
   output logic      o_empty,
   output intr_rec_t o_data
);

   localparam int AW = $clog2(FIFO_DEPTH);

   intr_rec_t        r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Pointer update; reset flushes the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage write; contents need no reset because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   // Head record, forced to zero while nothing is queued.
   always_comb begin
      o_data = '0;
      if (o_empty) begin
         o_data = '0;
      end else begin
         o_data = r_mem[r_rd_ptr[AW-1:0]];
      end
   end

endmodule

// File: rtl/noc_intr_rx.sv
// NoC interrupt receive endpoint: parses headers, buffers interrupts for this tile, drains the rest.
module noc_intr_rx
   import noc_intr_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NOC_X_WIDTH-1:0]    my_x,
   input  logic [NOC_Y_WIDTH-1:0]    my_y,
   input  logic                      noc_in_val,
   output logic                      noc_in_rdy,
   input  logic [NOC_DATA_WIDTH-1:0] noc_in_data,
   output logic                      intr_val,
   input  logic                      intr_rdy,
   output logic [31:0]               intr_tile,
   output logic [1:0]                intr_type,
   output logic [8:0]                intr_low,
   output logic [15:0]               drop_cnt
);

   rx_state_e                   r_state;
   rx_state_e                   w_next_state;
   logic                        r_rdy_en;
   logic [MSG_LENGTH_WIDTH-1:0] r_drain_cnt;
   logic [15:0]                 r_drop_cnt;

   logic [NOC_X_WIDTH-1:0]      w_hdr_x;
   logic [NOC_Y_WIDTH-1:0]      w_hdr_y;
   logic [MSG_LENGTH_WIDTH-1:0] w_hdr_len;
   logic [MSG_TYPE_WIDTH-1:0]   w_hdr_type;
   logic                        w_good;
   logic                        w_rdy;
   logic                        w_accept;
   logic                        w_hdr_accept;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_fifo_full;
   logic                        w_fifo_empty;
   intr_rec_t                   w_head_rec;
   logic                        w_unused_bits;

   assign w_hdr_x      = noc_in_data[MSG_DST_X_HI:MSG_DST_X_LO];
   assign w_hdr_y      = noc_in_data[MSG_DST_Y_HI:MSG_DST_Y_LO];
   assign w_hdr_len    = noc_in_data[MSG_LENGTH_HI:MSG_LENGTH_LO];
   assign w_hdr_type   = noc_in_data[MSG_TYPE_HI:MSG_TYPE_LO];
   assign w_good       = (w_hdr_type == MSG_TYPE_INTERRUPT) && (w_hdr_len == 8'd1) &&
                         (w_hdr_x == my_x) && (w_hdr_y == my_y);
   assign w_accept     = noc_in_val && w_rdy;
   assign w_hdr_accept = w_accept && (r_state == ST_HDR);
   assign w_push       = w_accept && (r_state == ST_CAPT);
   assign w_pop        = intr_rdy && !w_fifo_empty;
   assign w_unused_bits = ^noc_in_data;

   noc_intr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (decode_payload(noc_in_data)),
      .i_pop   (w_pop),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_data  (w_head_rec)
   );

   assign noc_in_rdy = w_rdy;
   assign intr_val   = !w_fifo_empty;
   assign intr_tile  = w_head_rec.tile;
   assign intr_type  = w_head_rec.itype;
   assign intr_low   = w_head_rec.low;
   assign drop_cnt   = r_drop_cnt;

   // State register plus the enable that holds the link off until the cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_HDR;
         r_rdy_en <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_rdy_en <= 1'b1;
      end
   end

   // Next-state and link-ready; ready in CAPT depends only on registered FIFO fullness.
   always_comb begin
      w_next_state = r_state;
      w_rdy        = 1'b0;
      case (r_state)
         ST_HDR: begin
            w_rdy = r_rdy_en;
            if (w_accept) begin
               if (w_good) begin
                  w_next_state = ST_CAPT;
               end else if (w_hdr_len != 8'd0) begin
                  w_next_state = ST_DRAIN;
               end else begin
                  w_next_state = ST_HDR;
               end
            end else begin
               w_next_state = ST_HDR;
            end
         end
         ST_CAPT: begin
            w_rdy = r_rdy_en && !w_fifo_full;
            if (w_accept) begin
               w_next_state = ST_HDR;
            end else begin
               w_next_state = ST_CAPT;
            end
         end
         ST_DRAIN: begin
            w_rdy = r_rdy_en;
            if (w_accept && (r_drain_cnt == 8'd1)) begin
               w_next_state = ST_HDR;
            end else begin
               w_next_state = ST_DRAIN;
            end
         end
         default: begin
            w_rdy        = 1'b0;
            w_next_state = ST_HDR;
         end
      endcase
   end

   // Remaining-flit counter for packets being discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_cnt <= 8'd0;
      end else if (w_hdr_accept && !w_good) begin
         r_drain_cnt <= w_hdr_len;
      end else if (w_accept && (r_state == ST_DRAIN)) begin
         r_drain_cnt <= r_drain_cnt - 8'd1;
      end else begin
         r_drain_cnt <= r_drain_cnt;
      end
   end

   // Saturating count of rejected headers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= 16'd0;
      end else if (w_hdr_accept && !w_good && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

endmodule
